// File: rtl/piso_pkg.sv
// Shared types for the PISO serializer: FSM state encoding and
// counter width helper.
package piso_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      PARITY
   } state_t;

   function automatic int CNT_W(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/piso_shift_core.sv
// Shift register, beat counter and frame FSM of the serializer.
// Optional trailing parity bit when PISO_PARITY_EN is defined.
module piso_shift_core
   import piso_pkg::*;
#(
   parameter int WIDTH = 8
`ifdef PISO_PARITY_EN
   ,
   parameter bit PARITY_ODD = 1'b0
`endif
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_lsb,
   input  logic             ready_in,
   output logic             data_o,
   output logic             valid_out,
   output logic             last_out,
   output logic             idle,
   output logic             frame_end
);

   localparam int CW = CNT_W(WIDTH);

   state_t           state;
   logic [WIDTH-1:0] sr;
   logic [CW-1:0]    cnt;
   logic             lsb;
   logic             beat;
`ifdef PISO_PARITY_EN
   logic             par;
`endif

   assign valid_out = (state != IDLE);
   assign idle      = (state == IDLE);
   assign beat      = valid_out && ready_in;
   assign frame_end = beat && last_out;

   always_comb begin
      data_o   = 1'b0;
      last_out = 1'b0;
      unique case (state)
         SHIFT: begin
            data_o = lsb ? sr[0] : sr[WIDTH-1];
`ifndef PISO_PARITY_EN
            last_out = (cnt == CW'(1));
`endif
         end
`ifdef PISO_PARITY_EN
         PARITY: begin
            data_o   = par;
            last_out = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         sr    <= '0;
         cnt   <= '0;
         lsb   <= 1'b0;
`ifdef PISO_PARITY_EN
         par   <= 1'b0;
`endif
      end else if (load) begin
         // load wins over the final beat so the next frame follows gap-free
         state <= SHIFT;
         sr    <= load_data;
         cnt   <= CW'(WIDTH);
         lsb   <= load_lsb;
`ifdef PISO_PARITY_EN
         par   <= ^load_data ^ PARITY_ODD;
`endif
      end else if (beat) begin
         unique case (state)
            SHIFT: begin
               sr  <= lsb ? {1'b0, sr[WIDTH-1:1]}
                          : {sr[WIDTH-2:0], 1'b0};
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
`ifdef PISO_PARITY_EN
                  state <= PARITY;
`else
                  state <= IDLE;
`endif
               end
            end
            PARITY:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with holding register for
// back-to-back frames. Define PISO_PARITY_EN for a trailing parity bit.
module piso_serializer
   import piso_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data_i,
   input  logic             lsb_first_i,
   input  logic             valid_in,
   output logic             ready_out,
   output logic             data_o,
   output logic             valid_out,
   input  logic             ready_in,
   output logic             last_out,
   output logic             busy_out
);

   logic [WIDTH-1:0] hr_data;
   logic             hr_lsb;
   logic             hr_full;
   logic             hr_full_next;
   logic             hr_load;
   logic             in_xfer;
   logic             core_free;
   logic             core_idle;
   logic             frame_end;
   logic             load;
   logic [WIDTH-1:0] load_data;
   logic             load_lsb;

   always_comb begin
      in_xfer      = valid_in && ready_out;
      core_free    = core_idle || frame_end;
      load         = 1'b0;
      load_data    = data_i;
      load_lsb     = lsb_first_i;
      hr_load      = 1'b0;
      hr_full_next = hr_full;
      if (core_free && hr_full) begin
         load         = 1'b1;
         load_data    = hr_data;
         load_lsb     = hr_lsb;
         hr_load      = in_xfer;
         hr_full_next = in_xfer;
      end else if (core_free) begin
         load = in_xfer;
      end else begin
         hr_load      = in_xfer;
         hr_full_next = hr_full || in_xfer;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         hr_data   <= '0;
         hr_lsb    <= 1'b0;
         hr_full   <= 1'b0;
         ready_out <= 1'b0;
      end else begin
         if (hr_load) begin
            hr_data <= data_i;
            hr_lsb  <= lsb_first_i;
         end
         hr_full   <= hr_full_next;
         ready_out <= !hr_full_next;
      end
   end

   assign busy_out = valid_out || hr_full;

   piso_shift_core #(
      .WIDTH(WIDTH)
`ifdef PISO_PARITY_EN
      ,
      .PARITY_ODD(PARITY_ODD)
`endif
   ) u_core (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .load      (load),
      .load_data (load_data),
      .load_lsb  (load_lsb),
      .ready_in  (ready_in),
      .data_o    (data_o),
      .valid_out (valid_out),
      .last_out  (last_out),
      .idle      (core_idle),
      .frame_end (frame_end)
   );

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: directed cases plus
// randomized traffic against a bit-queue reference model.
module tb_piso_serializer;

   localparam int W = 8;
   localparam bit PODD = 1'b0;
`ifdef PISO_PARITY_EN
   localparam int FL  = W + 1;
   localparam bit PAR = 1'b1;
`else
   localparam int FL  = W;
   localparam bit PAR = 1'b0;
`endif

   logic         clk_in = 1'b0;
   logic         rst_n = 1'b1;
   logic [W-1:0] data_i = '0;
   logic         lsb_first_i = 1'b0;
   logic         valid_in = 1'b0;
   logic         ready_in = 1'b1;
   logic         ready_out;
   logic         data_o;
   logic         valid_out;
   logic         last_out;
   logic         busy_out;

   int           checks = 0;
   int           failures = 0;
   logic [1:0]   q[$];
   bit           acc;
   bit           rnd_ready = 1'b0;
   int           fbeats = 0;
   int           lastpos = 0;
   logic         lastbit = 1'b0;
   int           vcyc = 0;

   piso_serializer #(.WIDTH(W), .PARITY_ODD(PODD)) dut (
      .clk_in      (clk_in),
      .rst_n       (rst_n),
      .data_i      (data_i),
      .lsb_first_i (lsb_first_i),
      .valid_in    (valid_in),
      .ready_out   (ready_out),
      .data_o      (data_o),
      .valid_out   (valid_out),
      .ready_in    (ready_in),
      .last_out    (last_out),
      .busy_out    (busy_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected frame as {bit, last} entries in transmit order
   task automatic push_word(input logic [W-1:0] w, input logic lsb);
      for (int i = 0; i < W; i++) begin
         logic b;
         b = lsb ? w[i] : w[W-1-i];
         q.push_back({b, (i == W - 1) && !PAR});
      end
      if (PAR) q.push_back({^w ^ PODD, 1'b1});
   endtask

   task automatic tick();
      logic [1:0] e;
      @(negedge clk_in);
      if (valid_out) vcyc++;
      if (rst_n && valid_in && ready_out) begin
         push_word(data_i, lsb_first_i);
         acc = 1'b1;
      end
      if (valid_out && ready_in) begin
         fbeats++;
         if (q.size() == 0) begin
            chk("spurious_beat", {31'b0, valid_out}, 32'd0);
         end else begin
            e = q.pop_front();
            chk("data_o", {31'b0, data_o}, {31'b0, e[1]});
            chk("last_out", {31'b0, last_out}, {31'b0, e[0]});
         end
         if (last_out) begin
            lastpos = fbeats;
            lastbit = data_o;
            fbeats  = 0;
         end
      end
      @(posedge clk_in);
      #1;
      if (rnd_ready) ready_in = ($urandom_range(0, 3) != 0);
   endtask

   task automatic send(input logic [W-1:0] w, input logic lsb);
      data_i      = w;
      lsb_first_i = lsb;
      valid_in    = 1'b1;
      acc         = 1'b0;
      for (int k = 0; k < 200 && !acc; k++) tick();
      valid_in = 1'b0;
      chk("accept", {31'b0, acc}, 32'd1);
   endtask

   task automatic drain();
      for (int k = 0; k < 2000 && (q.size() != 0 || valid_out); k++)
         tick();
      chk("drain_q", q.size(), 32'd0);
      chk("idle_valid", {31'b0, valid_out}, 32'd0);
      chk("idle_busy", {31'b0, busy_out}, 32'd0);
      chk("idle_ready", {31'b0, ready_out}, 32'd1);
   endtask

   initial begin
      #2 rst_n = 1'b0;
      #1;
      chk("rst_data", {31'b0, data_o}, 32'd0);
      chk("rst_valid", {31'b0, valid_out}, 32'd0);
      chk("rst_last", {31'b0, last_out}, 32'd0);
      chk("rst_busy", {31'b0, busy_out}, 32'd0);
      chk("rst_ready", {31'b0, ready_out}, 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      chk("ready_pre_edge", {31'b0, ready_out}, 32'd0);
      tick();
      chk("ready_post_edge", {31'b0, ready_out}, 32'd1);

      // reset three beats into a frame
      send(8'hFF, 1'b0);
      for (int k = 0; k < 50 && fbeats < 3; k++) tick();
      rst_n = 1'b0;
      #1;
      chk("midrst_data", {31'b0, data_o}, 32'd0);
      chk("midrst_valid", {31'b0, valid_out}, 32'd0);
      chk("midrst_last", {31'b0, last_out}, 32'd0);
      chk("midrst_busy", {31'b0, busy_out}, 32'd0);
      chk("midrst_ready", {31'b0, ready_out}, 32'd0);
      q.delete();
      fbeats = 0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      send(8'h3C, 1'b0);
      drain();
      chk("3c_len", lastpos, FL);

      // MSB first A5
      send(8'hA5, 1'b0);
      drain();
      chk("a5_len", lastpos, FL);

      // LSB first 01
      send(8'h01, 1'b1);
      drain();

      // back-to-back through the holding register
      vcyc = 0;
      data_i   = 8'hF0;
      valid_in = 1'b1;
      acc      = 1'b0;
      tick();
      chk("b2b_acc0", {31'b0, acc}, 32'd1);
      data_i = 8'h0F;
      acc    = 1'b0;
      tick();
      valid_in = 1'b0;
      chk("b2b_acc1", {31'b0, acc}, 32'd1);
      chk("hr_full_ready", {31'b0, ready_out}, 32'd0);
      chk("hr_full_busy", {31'b0, busy_out}, 32'd1);
      repeat (FL - 2) tick();
      chk("hr_still_full", {31'b0, ready_out}, 32'd0);
      tick();
      chk("hr_moved_ready", {31'b0, ready_out}, 32'd1);
      chk("b2b_no_gap", {31'b0, valid_out}, 32'd1);
      drain();
      chk("b2b_cycles", vcyc, 2 * FL);

      // downstream stall after bit 4
      vcyc = 0;
      send(8'hA5, 1'b0);
      for (int k = 0; k < 50 && fbeats < 4; k++) tick();
      ready_in = 1'b0;
      repeat (3) begin
         chk("stall_valid", {31'b0, valid_out}, 32'd1);
         chk("stall_data", {31'b0, data_o}, 32'd0);
         tick();
      end
      ready_in = 1'b1;
      drain();
      chk("stall_cycles", vcyc, FL + 3);

      // word 07: last bit is 1 with or without parity
      send(8'h07, 1'b0);
      drain();
      chk("07_lastpos", lastpos, FL);
      chk("07_lastbit", {31'b0, lastbit}, 32'd1);

      // randomized traffic with random gaps and backpressure
      rnd_ready = 1'b1;
      for (int n = 0; n < 60; n++) begin
         repeat ($urandom_range(0, 2)) tick();
         send(W'($urandom), 1'($urandom));
      end
      rnd_ready = 1'b0;
      ready_in  = 1'b1;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
